// File: rtl/gain_pkg.sv
// Shared constants and helpers for the multi-channel gain stage.
// Helpers return 64-bit values; callers size-cast to their own widths.
package gain_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_GAIN_WIDTH = 16;
  localparam int DEF_GAIN_FRAC  = 10;
  localparam int DEF_CHANNELS   = 2;
  localparam int DEF_SATURATE   = 1;

  function automatic longint unity_gain(input int frac);
    return longint'(1) <<< frac;
  endfunction

  function automatic longint smax(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint smin(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  localparam longint DEF_SMAX = smax(DEF_DATA_WIDTH);
  localparam longint DEF_SMIN = smin(DEF_DATA_WIDTH);
endpackage

// File: rtl/gain_round_sat.sv
// Combinational round-half-up, Q-format shift and optional clamp of a full product.
module gain_round_sat
  import gain_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int GAIN_WIDTH = DEF_GAIN_WIDTH,
  parameter int GAIN_FRAC  = DEF_GAIN_FRAC,
  parameter int SATURATE   = DEF_SATURATE
) (
  input  logic signed [DATA_WIDTH+GAIN_WIDTH-1:0] prod,
  output logic        [DATA_WIDTH-1:0]            result,
  output logic                                    clip
);
  // One guard bit so the rounding add can never overflow.
  localparam int SW = DATA_WIDTH + GAIN_WIDTH + 1;
  localparam logic signed [SW-1:0] RND  = SW'(unity_gain(GAIN_FRAC - 1));
  localparam logic signed [SW-1:0] MAXV = SW'(smax(DATA_WIDTH));
  localparam logic signed [SW-1:0] MINV = SW'(smin(DATA_WIDTH));

  logic signed [SW-1:0] sum, shifted;

  always_comb begin
    sum     = SW'(prod) + RND;
    shifted = sum >>> GAIN_FRAC;
    result  = shifted[DATA_WIDTH-1:0];
    clip    = 1'b0;
    if (SATURATE != 0) begin
      if (shifted > MAXV) begin
        result = MAXV[DATA_WIDTH-1:0];
        clip   = 1'b1;
      end else if (shifted < MINV) begin
        result = MINV[DATA_WIDTH-1:0];
        clip   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/gain_multi.sv
// Interleaved multi-channel Q-format gain: FWFT input FIFO -> multiply -> round/sat -> output FIFO.
// Two-stage pipeline, whole pipe stalls when S2 holds a word and the output FIFO is full.
module gain_multi
  import gain_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int GAIN_WIDTH = DEF_GAIN_WIDTH,
  parameter int GAIN_FRAC  = DEF_GAIN_FRAC,
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int SATURATE   = DEF_SATURATE
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    gain_load,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] gain_chan,
  input  logic [GAIN_WIDTH-1:0]   gain_value,
  input  logic                    in_empty,
  input  logic [DATA_WIDTH-1:0]   in_dout,
  output logic                    in_rd_en,
  input  logic                    out_full,
  output logic                    out_wr_en,
  output logic [DATA_WIDTH-1:0]   out_din,
  output logic [15:0]             sat_count
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW = DATA_WIDTH + GAIN_WIDTH;

  logic signed [GAIN_WIDTH-1:0] gain_reg [CHANNELS];
  logic [CW-1:0]                chan;
  logic [2:1]                   vld_pipe;
  logic signed [PW-1:0]         s1_prod;
  logic [DATA_WIDTH-1:0]        rs_result;
  logic                         rs_clip;
  logic                         advance, pop;

  assign advance   = !(vld_pipe[2] && out_full);
  assign pop       = !in_empty && advance;
  // Handshakes are masked during reset so neither FIFO moves while the pipe is flushed.
  assign in_rd_en  = reset && pop;
  assign out_wr_en = reset && vld_pipe[2] && !out_full;

  gain_round_sat #(
    .DATA_WIDTH(DATA_WIDTH),
    .GAIN_WIDTH(GAIN_WIDTH),
    .GAIN_FRAC (GAIN_FRAC),
    .SATURATE  (SATURATE)
  ) u_rs (
    .prod  (s1_prod),
    .result(rs_result),
    .clip  (rs_clip)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++) gain_reg[c] <= GAIN_WIDTH'(unity_gain(GAIN_FRAC));
      chan      <= '0;
      vld_pipe  <= '0;
      s1_prod   <= '0;
      out_din   <= '0;
      sat_count <= '0;
    end else begin
      // A pop this cycle still reads the old gain: the write lands at this edge.
      if (gain_load && (int'(gain_chan) < CHANNELS)) gain_reg[gain_chan] <= gain_value;
      if (advance) begin
        vld_pipe <= {vld_pipe[1], pop};
        if (pop) begin
          s1_prod <= PW'($signed(in_dout)) * PW'(gain_reg[chan]);
          chan    <= (int'(chan) == CHANNELS - 1) ? '0 : chan + 1'b1;
        end
        if (vld_pipe[1]) begin
          out_din <= rs_result;
          if (rs_clip && sat_count != 16'hFFFF) sat_count <= sat_count + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_gain_multi.sv
// Scoreboard bench for gain_multi: one saturating and one wrapping instance share stimulus.
module tb_gain_multi;
  logic        clock = 0;
  logic        reset, gain_load, gain_chan, in_empty, out_full;
  logic [15:0] gain_value;
  logic [31:0] in_dout;
  logic        rd0, wr0, rd1, wr1;
  logic [31:0] din0, din1;
  logic [15:0] sat0, sat1;

  always #5 clock = ~clock;

  gain_multi #(.DATA_WIDTH(32), .GAIN_WIDTH(16), .GAIN_FRAC(10), .CHANNELS(2), .SATURATE(1)) dut0 (
    .clock(clock), .reset(reset), .gain_load(gain_load), .gain_chan(gain_chan),
    .gain_value(gain_value), .in_empty(in_empty), .in_dout(in_dout), .in_rd_en(rd0),
    .out_full(out_full), .out_wr_en(wr0), .out_din(din0), .sat_count(sat0));

  gain_multi #(.DATA_WIDTH(32), .GAIN_WIDTH(16), .GAIN_FRAC(10), .CHANNELS(2), .SATURATE(0)) dut1 (
    .clock(clock), .reset(reset), .gain_load(gain_load), .gain_chan(gain_chan),
    .gain_value(gain_value), .in_empty(in_empty), .in_dout(in_dout), .in_rd_en(rd1),
    .out_full(out_full), .out_wr_en(wr1), .out_din(din1), .sat_count(sat1));

  typedef struct {
    logic [31:0] val;
    bit          clip;
    int          cyc;
  } exp_t;

  exp_t        q0[$], q1[$];
  logic [15:0] gain_m [2];
  int          chan_m, cyc, n_vec, n_err;
  int          sat_m0, sat_m1;
  bit          chk_lat, rnd_done;

  localparam longint HI = (longint'(1) <<< 31) - 1;
  localparam longint LO = -(longint'(1) <<< 31);

  // Reference: exact product, +0.5 LSB, floor divide by 2^10, then clamp or wrap.
  function automatic void model(input logic [31:0] x, input logic [15:0] g, input bit sat,
                                output logic [31:0] y, output bit clip);
    longint p, r;
    p    = longint'($signed(x)) * longint'($signed(g));
    r    = (p + 512) >>> 10;
    clip = 0;
    y    = r[31:0];
    if (sat && r > HI) begin y = 32'h7FFF_FFFF; clip = 1; end
    else if (sat && r < LO) begin y = 32'h8000_0000; clip = 1; end
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Model + monitor: pops/pushes decided from handshakes settled since the last edge.
  always @(negedge clock) begin
    logic [31:0] y;
    bit          c;
    exp_t        e;
    cyc++;
    if (!reset) begin
      q0.delete(); q1.delete();
      gain_m = '{16'h0400, 16'h0400};
      chan_m = 0; sat_m0 = 0; sat_m1 = 0;
    end else begin
      if (rd0) begin
        model(in_dout, gain_m[chan_m], 1, y, c); q0.push_back('{y, c, cyc});
        model(in_dout, gain_m[chan_m], 0, y, c); q1.push_back('{y, c, cyc});
        chan_m = (chan_m + 1) % 2;
      end
      if (gain_load) gain_m[gain_chan] = gain_value;
      if (wr0) begin
        if (q0.size() == 0) fail_now("dut0 unexpected output");
        else begin
          e = q0.pop_front();
          cmp("dut0 out_din", din0, e.val);
          if (chk_lat) cmp("dut0 latency", 32'(cyc - e.cyc), 32'd2);
          if (e.clip && sat_m0 < 16'hFFFF) sat_m0++;
        end
      end
      if (wr1) begin
        if (q1.size() == 0) fail_now("dut1 unexpected output");
        else begin
          e = q1.pop_front();
          cmp("dut1 out_din", din1, e.val);
          if (e.clip && sat_m1 < 16'hFFFF) sat_m1++;
        end
      end
    end
  end

  task automatic send(input logic [31:0] x);
    bit got = 0;
    in_empty = 0;
    in_dout  = x;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock);
      if (rd0) got = 1;
    end
    if (!got) fail_now("send pop");
    @(posedge clock); #1;
    in_empty  = 1;
    gain_load = 0;
  endtask

  task automatic load(input logic ch, input logic [15:0] v);
    gain_load = 1; gain_chan = ch; gain_value = v;
    @(posedge clock); #1;
    gain_load = 0;
  endtask

  task automatic drain_and_check_sat(input string tag);
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clock);
      if (q0.size() == 0 && q1.size() == 0) done = 1;
    end
    if (!done) fail_now({tag, " drain"});
    @(negedge clock);
    cmp({tag, " sat_count dut0"}, 32'(sat0), 32'(sat_m0));
    cmp({tag, " sat_count dut1"}, 32'(sat1), 32'(sat_m1));
    @(posedge clock); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; chk_lat = 1; rnd_done = 0;
    reset = 0; gain_load = 0; gain_chan = 0; gain_value = 0;
    in_empty = 0; in_dout = 32'h5; out_full = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    cmp("reset in_rd_en", 32'(rd0), 0);
    cmp("reset out_wr_en", 32'(wr0), 0);
    cmp("reset out_din", din0, 0);
    cmp("reset sat_count", 32'(sat0), 0);
    @(posedge clock); #1;
    reset = 1; in_empty = 1;
    @(posedge clock); #1;

    // unity gain
    send(32'h0000_1000);
    send(32'hFFFF_F000);
    drain_and_check_sat("unity");

    // per-channel gain
    load(0, 16'h0400);
    load(1, 16'h0800);
    repeat (4) send(32'd100);
    drain_and_check_sat("perchan");

    // rounding at gain 0.5
    load(0, 16'h0200);
    load(1, 16'h0200);
    send(32'd3);
    send(32'hFFFF_FFFD);
    send(32'd1);
    drain_and_check_sat("round");

    // saturation at gain 2.0
    load(0, 16'h0800);
    load(1, 16'h0800);
    send(32'h7FFF_FFFF);
    send(32'h8000_0000);
    drain_and_check_sat("sat");
    send(32'h4000_0000);
    drain_and_check_sat("wrap");

    // gain write colliding with a ch0 pop (chan is back at 0 after 12 pops)
    load(0, 16'h0400);
    load(1, 16'h0400);
    gain_load = 1; gain_chan = 0; gain_value = 16'h0800;
    send(32'd100);
    send(32'd100);
    send(32'd100);
    drain_and_check_sat("collide");

    // backpressure: 5 stalled cycles inside a gapless stream of 32 samples
    chk_lat = 0;
    load(0, 16'($urandom_range(0, 16'h0FFF)));
    load(1, 16'($urandom_range(0, 16'h0FFF)));
    fork
      for (int i = 0; i < 32; i++) send($urandom);
      begin
        repeat (10) @(posedge clock);
        #1 out_full = 1;
        repeat (5) begin
          @(negedge clock);
          cmp("stall in_rd_en dut0", 32'(rd0), 0);
          cmp("stall in_rd_en dut1", 32'(rd1), 0);
          cmp("stall out_wr_en", 32'(wr0), 0);
        end
        @(posedge clock); #1 out_full = 0;
      end
    join
    drain_and_check_sat("bp");

    // random gaps, random out_full, random gain loads
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
          if ($urandom_range(0, 3) == 0) begin
            gain_load = 1; gain_chan = 1'($urandom_range(0, 1)); gain_value = 16'($urandom);
          end
          send($urandom);
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clock); #1;
          out_full = ($urandom_range(0, 9) < 3);
        end
        out_full = 0;
      end
    join
    drain_and_check_sat("random");

    // reset mid-stream
    load(0, 16'h0300);
    load(1, 16'h0300);
    in_empty = 0; in_dout = $urandom;
    repeat (4) @(posedge clock);
    #1 reset = 0;
    @(posedge clock);
    @(negedge clock);
    cmp("midreset out_wr_en", 32'(wr0), 0);
    cmp("midreset sat_count dut0", 32'(sat0), 0);
    cmp("midreset in_rd_en", 32'(rd0), 0);
    @(posedge clock); #1;
    reset = 1; in_empty = 1;
    send(32'h1234_5678);
    send(32'hFFFF_0001);
    chk_lat = 1;
    drain_and_check_sat("postreset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
